// File: rtl/window3x3_gen_if.sv
// Stream interface for window3x3_gen: a pixel input channel and a window
// output channel, each with its own valid/ready handshake.
interface window3x3_gen_if;
  logic       in_valid;
  logic       in_pix;
  logic       in_ready;
  logic       out_valid;
  logic [8:0] out_win;
  logic       out_ready;
  logic       out_last;
  logic       frame_done;

  // Producer/consumer side (drives pixels, accepts windows)
  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_win, out_last, frame_done
  );

  // Window generator side
  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_win, out_last, frame_done
  );
endinterface

// File: rtl/window3x3_gen.sv
// window3x3_gen: turns a raster-order binary pixel stream into 3x3 windows
// for valid-only (unpadded) convolution. Two IMG_W-deep shift-register line
// buffers supply the two previous rows; a 3x3 window register slides one
// column per accepted pixel; a single output register stage holds each
// window until the consumer takes it.
module window3x3_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CW    = 5,
  parameter int RW    = 5
) (
  input logic            clk,
  input logic            rst_n,
  window3x3_gen_if.slave bus
);

  logic [CW-1:0]    col_r;
  logic [RW-1:0]    row_r;
  logic [IMG_W-1:0] lb0_r;
  logic [IMG_W-1:0] lb1_r;
  logic [8:0]       win_r;
  logic [8:0]       win_next_s;
  logic [8:0]       out_win_r;
  logic             out_valid_r;
  logic             out_last_r;
  logic             frame_done_r;
  logic             in_ready_s;
  logic             accept_s;
  logic             consume_s;
  logic             load_s;
  logic             pix_s;
  logic             col_end_s;
  logic             row_end_s;

  // Single output stage: a pixel may enter whenever the held window is
  // absent or leaving this cycle, so the stream runs without bubbles.
  assign in_ready_s = ~out_valid_r | bus.out_ready;
  assign accept_s   = bus.in_valid & in_ready_s;
  assign consume_s  = out_valid_r & bus.out_ready;
  // Gate the pixel with valid so an undriven pixel never enters the buffers.
  assign pix_s      = bus.in_valid & bus.in_pix;
  assign col_end_s  = (col_r == CW'(IMG_W - 1));
  assign row_end_s  = (row_r == RW'(IMG_H - 1));
  // Only positions with two full rows and two full columns behind them
  // complete a window; the window slides across row wraps but is not emitted.
  assign load_s     = accept_s & (row_r >= RW'(2)) & (col_r >= CW'(2));

  // Raster position of the next pixel to arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r <= {CW{1'b0}};
      row_r <= {RW{1'b0}};
    end else if (accept_s) begin
      if (col_end_s) begin
        col_r <= {CW{1'b0}};
        row_r <= row_end_s ? {RW{1'b0}} : row_r + RW'(1);
      end else begin
        col_r <= col_r + CW'(1);
        row_r <= row_r;
      end
    end else begin
      col_r <= col_r;
      row_r <= row_r;
    end
  end

  // Line buffers: the oldest bit of each is the same column one row earlier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb0_r <= {IMG_W{1'b0}};
      lb1_r <= {IMG_W{1'b0}};
    end else if (accept_s) begin
      lb0_r <= {lb0_r[IMG_W-2:0], pix_s};
      lb1_r <= {lb1_r[IMG_W-2:0], lb0_r[IMG_W-1]};
    end else begin
      lb0_r <= lb0_r;
      lb1_r <= lb1_r;
    end
  end

  // Slide the window one column left; new right column is rows r-2, r-1, r.
  always_comb begin
    win_next_s    = win_r;
    win_next_s[0] = win_r[1];
    win_next_s[1] = win_r[2];
    win_next_s[2] = lb1_r[IMG_W-1];
    win_next_s[3] = win_r[4];
    win_next_s[4] = win_r[5];
    win_next_s[5] = lb0_r[IMG_W-1];
    win_next_s[6] = win_r[7];
    win_next_s[7] = win_r[8];
    win_next_s[8] = pix_s;
  end

  // Window register advances on every accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_r <= 9'h000;
    end else if (accept_s) begin
      win_r <= win_next_s;
    end else begin
      win_r <= win_r;
    end
  end

  // Output stage: load a completed window, or drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_win_r   <= 9'h000;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (load_s) begin
      out_win_r   <= win_next_s;
      out_valid_r <= 1'b1;
      out_last_r  <= row_end_s & col_end_s;
    end else if (consume_s) begin
      out_win_r   <= out_win_r;
      out_valid_r <= 1'b0;
      out_last_r  <= out_last_r;
    end else begin
      out_win_r   <= out_win_r;
      out_valid_r <= out_valid_r;
      out_last_r  <= out_last_r;
    end
  end

  // One-cycle pulse after the final window of a frame has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= consume_s & out_last_r;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_win    = out_win_r;
  assign bus.out_last   = out_last_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_window3x3_gen.sv
// Self-checking bench for window3x3_gen: a 4x4 instance driven from a table
// of frame patterns with hand-derived expected windows, a reset-mid-frame
// sequence, and a default 28x28 instance streamed with an all-ones frame.
// Expected windows are queued as pixels are accepted and popped by monitors.
module tb_window3x3_gen;

  typedef struct {
    int               pat;    // 0 checker, 1 column ramp, 2 single hot (1,1), 3 ones
    bit               stall;  // toggle out_ready every cycle
    int               nfr;    // frames sent back to back
    logic [0:3][8:0]  w;      // windows at (2,2),(2,3),(3,2),(3,3)
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;
  int   fd4_cnt = 0;
  int   fd28_cnt = 0;
  int   win28_cnt = 0;
  logic [9:0] q4[$];
  logic [9:0] q28[$];
  vec_t tab[5];

  always #5 clk = ~clk;

  window3x3_gen_if if4();
  window3x3_gen_if if28();

  window3x3_gen #(.IMG_W(4), .IMG_H(4), .CW(2), .RW(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4)
  );

  window3x3_gen u_dut28 (
    .clk(clk), .rst_n(rst_n), .bus(if28)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic pix(input int pat, input int r, input int c);
    case (pat)
      0:       return logic'((r + c) % 2);
      1:       return logic'((r * 4 + c) % 2);
      2:       return logic'(r == 1 && c == 1);
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor for the 4x4 instance: scoreboard pops, stall and frame_done checks.
  initial begin
    logic [9:0] e;
    logic [8:0] pw;
    logic       pl;
    bit         ps;
    bit         fde;
    ps = 1'b0; fde = 1'b0; pw = 9'h000; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ps = 1'b0; fde = 1'b0;
      end else begin
        if (if4.frame_done || fde) chk("frame_done4", if4.frame_done, fde);
        if (if4.frame_done) fd4_cnt++;
        fde = 1'b0;
        if (ps) begin
          chk("stall_hold_win4", if4.out_win, pw);
          chk("stall_hold_last4", if4.out_last, pl);
        end
        ps = if4.out_valid && !if4.out_ready;
        if (ps) chk("stall_in_ready4", if4.in_ready, 0);
        pw = if4.out_win; pl = if4.out_last;
        if (if4.out_valid && if4.out_ready) begin
          if (q4.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_win4: got window %03h expected none at %0t", if4.out_win, $time);
          end else begin
            e = q4.pop_front();
            chk("win4", if4.out_win, e[8:0]);
            chk("last4", if4.out_last, e[9]);
          end
          fde = if4.out_last;
        end
      end
    end
  end

  // Monitor for the 28x28 instance.
  initial begin
    logic [9:0] e;
    bit         fde;
    fde = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        fde = 1'b0;
      end else begin
        if (if28.frame_done || fde) chk("frame_done28", if28.frame_done, fde);
        if (if28.frame_done) fd28_cnt++;
        fde = 1'b0;
        if (if28.out_valid && if28.out_ready) begin
          win28_cnt++;
          if (q28.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_win28: got window %03h expected none at %0t", if28.out_win, $time);
          end else begin
            e = q28.pop_front();
            chk("win28", if28.out_win, e[8:0]);
            chk("last28", if28.out_last, e[9]);
          end
          fde = if28.out_last;
        end
      end
    end
  end

  task automatic run4(input vec_t v);
    int  k = 0;
    int  guard = 0;
    int  fd0 = fd4_cnt;
    int  r, c;
    bit  acc, pushed, tog;
    tog = 1'b1;
    while (k < 16 * v.nfr && guard < 2000) begin
      r = (k % 16) / 4;
      c = k % 4;
      if4.in_valid  = 1'b1;
      if4.in_pix    = pix(v.pat, r, c);
      if4.out_ready = v.stall ? tog : 1'b1;
      tog = ~tog;
      @(negedge clk);
      acc = if4.in_ready;
      pushed = acc && r >= 2 && c >= 2;
      if (pushed) q4.push_back({logic'(r == 3 && c == 3), v.w[(r - 2) * 2 + (c - 2)]});
      @(posedge clk); #1;
      if (pushed) chk("latency4", if4.out_valid, 1);
      if (acc) k++;
      guard++;
    end
    if4.in_valid  = 1'b0;
    if4.in_pix    = 1'bx;
    if4.out_ready = 1'b1;
    guard = 0;
    while (q4.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pixels_sent4", k, 16 * v.nfr);
    chk("drain4", q4.size(), 0);
    chk("frame_done_count4", fd4_cnt - fd0, v.nfr);
    chk("idle_valid4", if4.out_valid, 0);
  endtask

  task automatic run28();
    int k = 0;
    int guard = 0;
    int r, c;
    bit acc, pushed;
    while (k < 784 && guard < 3000) begin
      r = k / 28;
      c = k % 28;
      if28.in_valid  = 1'b1;
      if28.in_pix    = 1'b1;
      if28.out_ready = 1'b1;
      @(negedge clk);
      acc = if28.in_ready;
      pushed = acc && r >= 2 && c >= 2;
      if (pushed) q28.push_back({logic'(r == 27 && c == 27), 9'h1FF});
      @(posedge clk); #1;
      if (pushed) chk("latency28", if28.out_valid, 1);
      if (acc) k++;
      guard++;
    end
    if28.in_valid = 1'b0;
    guard = 0;
    while (q28.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pixels_sent28", k, 784);
    chk("drain28", q28.size(), 0);
    chk("window_count28", win28_cnt, 676);
    chk("frame_done_count28", fd28_cnt, 1);
  endtask

  initial begin
    tab[0] = '{0, 1'b0, 1, {9'h0AA, 9'h155, 9'h155, 9'h0AA}};
    tab[1] = '{1, 1'b1, 1, {9'h092, 9'h16D, 9'h092, 9'h16D}};
    tab[2] = '{2, 1'b0, 1, {9'h010, 9'h008, 9'h002, 9'h001}};
    tab[3] = '{3, 1'b1, 1, {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}};
    tab[4] = '{0, 1'b0, 2, {9'h0AA, 9'h155, 9'h155, 9'h0AA}};

    rst_n = 1'b0;
    if4.in_valid = 1'b0;  if4.in_pix = 1'b0;  if4.out_ready = 1'b1;
    if28.in_valid = 1'b0; if28.in_pix = 1'b0; if28.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid4", if4.out_valid, 0);
    chk("rst_out_win4", if4.out_win, 0);
    chk("rst_out_last4", if4.out_last, 0);
    chk("rst_frame_done4", if4.frame_done, 0);
    chk("rst_in_ready4", if4.in_ready, 1);
    chk("rst_out_valid28", if28.out_valid, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run4(tab[i]);

    // Reset mid-frame with a window held under back-pressure.
    if4.out_ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      if4.in_valid = 1'b1;
      if4.in_pix   = pix(0, k / 4, k % 4);
      @(posedge clk); #1;
    end
    if4.in_valid = 1'b0;
    chk("pre_reset_valid4", if4.out_valid, 1);
    chk("pre_reset_win4", if4.out_win, 9'h0AA);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid4", if4.out_valid, 0);
    chk("async_rst_win4", if4.out_win, 0);
    q4.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    if4.out_ready = 1'b1;
    run4(tab[2]);

    run28();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/window3x3_gen.md
Name: window3x3_gen

Overview:
Streams a binarised image one pixel per transfer, raster order, and produces every fully-populated 3x3 neighbourhood as a 9-bit window for the downstream 9-input binary MAC. Valid convolution only, with no padding: a W x H frame yields (W-2)*(H-2) windows. It holds two line buffers and a 3x3 window register. It sits between the thresholding front end and the MAC array.

Parameters:
IMG_W, 28, pixels per row (>=3)
IMG_H, 28, rows per frame (>=3)
CW, 5, column counter width, ceil(log2(IMG_W))
RW, 5, row counter width, ceil(log2(IMG_H))

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  pixel present
in_pix  input  1  binary pixel
in_ready  output  1  block can accept pixel this cycle
out_valid  output  1  window register holds an unconsumed window
out_win  output  9  window, bit 3*i+j = P[r-2+i][c-2+j], i=row offset, j=col offset (bit0 top-left, bit8 bottom-right)
out_ready  input  1  consumer accepts window
out_last  output  1  qualifies out_valid: final window of frame
frame_done  output  1  one-cycle pulse when the last window is consumed

Behaviour:
- Reset (async assert, sync release): col=0, row=0, out_valid=0, out_win=0, out_last=0, frame_done=0; line buffers and window regs cleared to 0. Reset mid-frame discards the partial frame; the next accepted pixel is P[0][0].
- in_ready = !out_valid || out_ready (combinational; single output stage, full-throughput with no bubble).
- Accept = in_valid && in_ready. Nothing changes without an accept except out_valid clearing on consume.
- On accept of P[r][c]:
  - Shift the window left one column.
  - New right column = {line_buf1 tap (row r-2), line_buf0 tap (row r-1), in_pix}.
  - Push in_pix into line_buf0 and line_buf0 tap into line_buf1.
  - Each buffer is IMG_W deep.
- Counters on accept:
  - col increments.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At row=IMG_H-1 and col=IMG_W-1, both wrap to 0.
- Output register load: on an accept with r>=2 and c>=2, load out_win with the updated window on the next edge and set out_valid=1. Set out_last=1 iff r=IMG_H-1 and c=IMG_W-1.
- Latency: one cycle from pixel accept to out_valid.
- Consume: out_valid && out_ready. If no new load occurs in the same cycle, clear out_valid next edge. A simultaneous consume and load replaces the contents, and out_valid stays 1.
- Stall: out_valid && !out_ready gives in_ready=0. out_win and out_last are held stable.
- Rows 0-1 and columns 0-1 of each row produce no window; the window wraps across row boundaries but is never emitted there.
- frame_done = registered pulse, 1 cycle, after the cycle in which out_valid && out_ready && out_last.
- Back-to-back frames: the first pixel of the next frame may be accepted in the same cycle the last window is consumed.
- in_pix is ignored when in_valid=0. X on in_pix while in_valid=0 must not propagate.

Test Plan:
1. IMG_W=4, IMG_H=4, checkerboard P=(r+c)%2, in_valid=1, out_ready=1 -> exactly 4 windows: 0x0AA, 0x155, 0x155, 0x0AA. Each appears 1 cycle after pixels (2,2),(2,3),(3,2),(3,3). out_last only on the 4th. frame_done pulses once, 1 cycle later.
2. Default 28x28, all-ones frame, continuous flow -> 676 windows, all 0x1FF, no gaps after first window of each row. out_valid low during rows 0-1 and cols 0-1.
3. 4x4 ramp P=r*4+c mod 2 per bit, out_ready toggling 1/0 each cycle -> in_ready low whenever out_valid && !out_ready. out_win stable while stalled. Window sequence identical to the no-stall run.
4. Single pixel 1 at (1,1) in a 5x5 zero frame -> windows (2,2)=0x010, (2,3)=0x008, (3,2)=0x002, (3,3)=0x001. All other windows are 0x000.
5. Assert rst_n low after 10 pixels of a 4x4 frame, then send a full frame -> out_valid=0 immediately on reset. The new frame yields the 4 correct windows with no stale data.
6. Two 4x4 frames back-to-back with no idle -> 8 windows, two frame_done pulses. The second frame's first window matches a fresh-frame run.
